// File: rtl/mandelbrot_pkg.sv
// Shared types for the mandelbrot frame dispatcher.
// Fixed-point coordinate format and dispatcher state encoding.
package mandelbrot_pkg;

    localparam int FP_TOP  = 8;
    localparam int FP_BOT  = 24;
    localparam int FP_BITS = FP_TOP + FP_BOT;

    typedef logic signed [FP_BITS-1:0] fp_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_EMIT,
        ST_DONE
    } disp_state_e;

endpackage

// File: rtl/mandelbrot_dispatcher_if.sv
// Engine control bundle plus valid/ready pixel stream.
// The master side is the dispatcher; the slave side is engine + framebuffer writer.
interface mandelbrot_dispatcher_if
    import mandelbrot_pkg::*;
#(
    parameter int ADDR_W = 19,
    parameter int ITER_W = 8
);

    logic              eng_reset;
    fp_t               eng_x0;
    fp_t               eng_y0;
    logic [31:0]       eng_iterations_max;
    logic              eng_finished;
    logic [31:0]       eng_iterations;
    logic              pix_valid;
    logic              pix_ready;
    logic [ADDR_W-1:0] pix_addr;
    logic [ITER_W-1:0] pix_iter;

    modport master (
        output eng_reset, eng_x0, eng_y0, eng_iterations_max,
        output pix_valid, pix_addr, pix_iter,
        input  eng_finished, eng_iterations, pix_ready
    );

    modport slave (
        input  eng_reset, eng_x0, eng_y0, eng_iterations_max,
        input  pix_valid, pix_addr, pix_iter,
        output eng_finished, eng_iterations, pix_ready
    );

endinterface

// File: rtl/mandelbrot_coord_gen.sv
// Raster walker: col/row/addr counters and fixed-point cx/cy accumulators.
// init loads the frame origin and step; advance moves to the next pixel.
module mandelbrot_coord_gen
    import mandelbrot_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              advance,
    input  fp_t               x_start,
    input  fp_t               y_start,
    input  fp_t               step,
    output fp_t               cx,
    output fp_t               cy,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    fp_t           x_base;
    fp_t           dstep;
    logic          end_col;

    assign end_col = (col == CW'(WIDTH - 1));
    assign last    = end_col && (row == RW'(HEIGHT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            col    <= '0;
            row    <= '0;
            addr   <= '0;
            cx     <= '0;
            cy     <= '0;
            x_base <= '0;
            dstep  <= '0;
        end else if (init) begin
            col    <= '0;
            row    <= '0;
            addr   <= '0;
            cx     <= x_start;
            cy     <= y_start;
            x_base <= x_start;
            dstep  <= step;
        end else if (advance) begin
            addr <= addr + ADDR_W'(1);
            if (end_col) begin
                // Image y grows downward, so the imaginary part decreases per row.
                col <= '0;
                row <= row + RW'(1);
                cx  <= x_base;
                cy  <= cy - dstep;
            end else begin
                col <= col + CW'(1);
                cx  <= cx + dstep;
            end
        end
    end

endmodule

// File: rtl/mandelbrot_dispatcher.sv
// Drives one mandelbrot engine across a frame and streams out per-pixel results.
// Define MANDEL_ITER_SATURATE_EN to clamp pix_iter instead of truncating it.
module mandelbrot_dispatcher
    import mandelbrot_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int ITER_W = 8,
    parameter int ADDR_W = $clog2(WIDTH * HEIGHT)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  fp_t         x_start,
    input  fp_t         y_start,
    input  fp_t         step,
    input  logic [31:0] iterations_max,
    output logic        busy,
    output logic        done,
    mandelbrot_dispatcher_if.master bus
);

    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_LAUNCH = ST_LAUNCH;
    localparam logic [2:0] S_WAIT   = ST_WAIT;
    localparam logic [2:0] S_EMIT   = ST_EMIT;
    localparam logic [2:0] S_DONE   = ST_DONE;

    logic [2:0]        state;
    logic [31:0]       iter_max;
    logic [ITER_W-1:0] iter_q;
    logic [ITER_W-1:0] iter_next;
    logic [ADDR_W-1:0] addr;
    fp_t               cx;
    fp_t               cy;
    logic              last;
    logic              init;
    logic              advance;

    assign init    = (state == S_IDLE) && start;
    assign advance = (state == S_EMIT) && bus.pix_ready && !last;

    mandelbrot_coord_gen #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W)
    ) u_coord (
        .clk     (clk),
        .reset   (reset),
        .init    (init),
        .advance (advance),
        .x_start (x_start),
        .y_start (y_start),
        .step    (step),
        .cx      (cx),
        .cy      (cy),
        .addr    (addr),
        .last    (last)
    );

`ifdef MANDEL_ITER_SATURATE_EN
    assign iter_next = (|bus.eng_iterations[31:ITER_W]) ?
                       {ITER_W{1'b1}} : bus.eng_iterations[ITER_W-1:0];
`else
    logic unused_hi;
    assign unused_hi = ^bus.eng_iterations[31:ITER_W];
    assign iter_next = bus.eng_iterations[ITER_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            iter_max <= '0;
            iter_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        iter_max <= iterations_max;
                        state    <= S_LAUNCH;
                    end
                end
                S_LAUNCH: state <= S_WAIT;
                S_WAIT: begin
                    // Only sampled here: a finish left over from the prior pixel is cleared by LAUNCH.
                    if (bus.eng_finished) begin
                        iter_q <= iter_next;
                        state  <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (bus.pix_ready) state <= last ? S_DONE : S_LAUNCH;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_LAUNCH) || (state == S_WAIT) || (state == S_EMIT);
    assign done = (state == S_DONE);

    assign bus.eng_reset          = !((state == S_WAIT) || (state == S_EMIT));
    assign bus.eng_x0             = cx;
    assign bus.eng_y0             = cy;
    assign bus.eng_iterations_max = iter_max;
    assign bus.pix_valid          = (state == S_EMIT);
    assign bus.pix_addr           = addr;
    assign bus.pix_iter           = iter_q;

endmodule

// File: tb/tb_mandelbrot_dispatcher.sv
// Directed bench for mandelbrot_dispatcher on a 4x2 frame.
// A behavioural engine model answers each launch after a fixed latency.
module tb_mandelbrot_dispatcher;
    import mandelbrot_pkg::*;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int AW = 3;
    localparam int IW = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    fp_t         x_start;
    fp_t         y_start;
    fp_t         step;
    logic [31:0] iterations_max;
    logic        busy;
    logic        done;

    mandelbrot_dispatcher_if #(.ADDR_W(AW), .ITER_W(IW)) bus();

    mandelbrot_dispatcher #(
        .WIDTH(W), .HEIGHT(H), .ITER_W(IW), .ADDR_W(AW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .x_start        (x_start),
        .y_start        (y_start),
        .step           (step),
        .iterations_max (iterations_max),
        .busy           (busy),
        .done           (done),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    // Escape-time reference: iterate, stop when |z|^2 > 4 or the limit is hit.
    function automatic int unsigned mand(fp_t cr, fp_t ci, logic [31:0] mx);
        longint zr = 0, zi = 0, tr, ti;
        int unsigned n = 0;
        while (n < mx) begin
            tr = ((zr * zr - zi * zi) >>> 24) + longint'(cr);
            ti = ((2 * zr * zi) >>> 24) + longint'(ci);
            zr = tr;
            zi = ti;
            n++;
            if (zr * zr + zi * zi > (longint'(4) <<< 48)) break;
        end
        return n;
    endfunction

    logic started;
    int   cnt;
    always @(posedge clk) begin
        if (bus.eng_reset) begin
            bus.eng_finished <= 1'b0;
            started <= 1'b0;
            cnt <= 0;
        end else if (!started) begin
            started <= 1'b1;
            bus.eng_iterations <= mand(bus.eng_x0, bus.eng_y0, bus.eng_iterations_max);
        end else if (!bus.eng_finished) begin
            cnt <= cnt + 1;
            if (cnt == 2) bus.eng_finished <= 1'b1;
        end
    end

    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    int          cap_n;
    logic        cap_done;
    logic [AW-1:0] cap_addr[16];
    logic [IW-1:0] cap_iter[16];
    fp_t         cap_x[16];
    fp_t         cap_y[16];

    task automatic launch(fp_t x, fp_t y, fp_t s, logic [31:0] m);
        @(negedge clk);
        x_start = x; y_start = y; step = s; iterations_max = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic collect(int budget);
        cap_n = 0;
        cap_done = 1'b0;
        for (int c = 0; c < budget && !cap_done; c++) begin
            @(negedge clk);
            if (bus.pix_valid && bus.pix_ready) begin
                if (cap_n < 16) begin
                    cap_addr[cap_n] = bus.pix_addr;
                    cap_iter[cap_n] = bus.pix_iter;
                    cap_x[cap_n] = bus.eng_x0;
                    cap_y[cap_n] = bus.eng_y0;
                end
                cap_n++;
            end
            if (done) cap_done = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1;
        x_start = 32'h01000000; y_start = 32'h01000000;
        step = 32'h00100000; iterations_max = 32'd7;
        bus.pix_ready = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
        tests++; if (bus.pix_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", bus.pix_valid); end
        tests++; if (bus.eng_reset !== 1'b1) begin fails++; $display("FAIL reset_eng_reset got %b want 1", bus.eng_reset); end
        tests++; if (bus.pix_addr !== '0) begin fails++; $display("FAIL reset_addr got %0d want 0", bus.pix_addr); end
        tests++; if (bus.pix_iter !== '0) begin fails++; $display("FAIL reset_iter got %0d want 0", bus.pix_iter); end
        tests++; if (bus.eng_x0 !== '0 || bus.eng_y0 !== '0) begin
            fails++; $display("FAIL reset_xy got %h/%h want 0/0", bus.eng_x0, bus.eng_y0);
        end
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_wins got busy %b want 0", busy); end
    endtask

    task automatic test_frame();
        int exp_it[8] = '{1, 2, 3, 4, 1, 3, 5, 16};
        fp_t exp_x[4] = '{32'hFE000000, 32'hFE800000, 32'hFF000000, 32'hFF800000};
        fp_t exp_y[2] = '{32'h01000000, 32'h00800000};
        int d0 = done_cnt;
        launch(32'hFE000000, 32'h01000000, 32'h00800000, 32'd16);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL frame_busy got %b want 1", busy); end
        collect(300);
        tests++; if (!cap_done || cap_n != 8) begin
            fails++; $display("FAIL frame_count got %0d pixels done=%b want 8 done=1", cap_n, cap_done);
        end
        for (int i = 0; i < 8 && i < cap_n; i++) begin
            tests++;
            if (cap_addr[i] !== AW'(i) || cap_iter[i] !== IW'(exp_it[i]) ||
                cap_x[i] !== exp_x[i % 4] || cap_y[i] !== exp_y[i / 4]) begin
                fails++;
                $display("FAIL frame_px%0d got a=%0d it=%0d x=%h y=%h want a=%0d it=%0d x=%h y=%h",
                         i, cap_addr[i], cap_iter[i], cap_x[i], cap_y[i],
                         i, exp_it[i], exp_x[i % 4], exp_y[i / 4]);
            end
        end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL frame_busy_done got %b want 0", busy); end
        repeat (3) @(negedge clk);
        tests++; if (done_cnt - d0 != 1) begin
            fails++; $display("FAIL frame_done_pulses got %0d want 1", done_cnt - d0);
        end
    endtask

    task automatic test_limits();
        launch(32'h0, 32'h0, 32'h0, 32'd50);
        collect(300);
        tests++; if (cap_n != 8 || !cap_done) begin fails++; $display("FAIL lim50_count got %0d want 8", cap_n); end
        for (int i = 0; i < 8 && i < cap_n; i++) begin
            tests++; if (cap_iter[i] !== 8'd50) begin
                fails++; $display("FAIL lim50_px%0d got %0d want 50", i, cap_iter[i]);
            end
        end
        launch(32'h0, 32'h0, 32'h0, 32'd0);
        collect(300);
        tests++; if (cap_n != 8 || !cap_done) begin fails++; $display("FAIL lim0_count got %0d want 8", cap_n); end
        for (int i = 0; i < 8 && i < cap_n; i++) begin
            tests++; if (cap_iter[i] !== 8'd0) begin
                fails++; $display("FAIL lim0_px%0d got %0d want 0", i, cap_iter[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic found = 1'b0;
        launch(32'hFE000000, 32'h01000000, 32'h00800000, 32'd16);
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (bus.pix_valid && bus.pix_addr == 3'd2) begin
                bus.pix_ready = 1'b0;
                found = 1'b1;
            end
        end
        tests++; if (!found) begin fails++; $display("FAIL stall_reach got timeout want addr 2"); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tests++;
            if (bus.pix_valid !== 1'b1 || bus.pix_addr !== 3'd2 ||
                bus.pix_iter !== 8'd3 || bus.eng_reset !== 1'b0) begin
                fails++;
                $display("FAIL stall_hold%0d got v=%b a=%0d it=%0d er=%b want v=1 a=2 it=3 er=0",
                         k, bus.pix_valid, bus.pix_addr, bus.pix_iter, bus.eng_reset);
            end
        end
        bus.pix_ready = 1'b1;
        @(negedge clk);
        tests++; if (bus.pix_valid !== 1'b0 || bus.pix_addr !== 3'd3) begin
            fails++; $display("FAIL stall_release got v=%b a=%0d want v=0 a=3", bus.pix_valid, bus.pix_addr);
        end
        collect(300);
        tests++; if (cap_n != 5 || !cap_done || cap_addr[0] !== 3'd3) begin
            fails++; $display("FAIL stall_rest got n=%0d a0=%0d want n=5 a0=3", cap_n, cap_addr[0]);
        end
    endtask

    task automatic test_saturate();
        logic [IW-1:0] exp;
`ifdef MANDEL_ITER_SATURATE_EN
        exp = 8'd255;
`else
        exp = 8'd44;
`endif
        launch(32'h0, 32'h0, 32'h0, 32'd300);
        collect(300);
        tests++; if (cap_n != 8 || !cap_done) begin fails++; $display("FAIL sat_count got %0d want 8", cap_n); end
        for (int i = 0; i < 8 && i < cap_n; i++) begin
            tests++; if (cap_iter[i] !== exp) begin
                fails++; $display("FAIL sat_px%0d got %0d want %0d", i, cap_iter[i], exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic found;
        logic seen;
        int d0;
        launch(32'hFE000000, 32'h01000000, 32'h00800000, 32'd16);
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (bus.pix_valid && bus.pix_addr == 3'd1) found = 1'b1;
        end
        x_start = 32'h0; y_start = 32'h0; step = 32'h0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (bus.pix_valid && bus.pix_addr == 3'd2) found = 1'b1;
        end
        tests++; if (!found || bus.eng_x0 !== 32'hFF000000 || bus.eng_y0 !== 32'h01000000) begin
            fails++; $display("FAIL midstart_ignored got f=%b x=%h y=%h want x=ff000000 y=01000000",
                              found, bus.eng_x0, bus.eng_y0);
        end
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (bus.pix_addr == 3'd3 && !bus.eng_reset && !bus.pix_valid) found = 1'b1;
        end
        tests++; if (!found) begin fails++; $display("FAIL midreset_reach got timeout want WAIT at addr 3"); end
        d0 = done_cnt;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests++;
        if (busy !== 1'b0 || bus.pix_valid !== 1'b0 || bus.eng_reset !== 1'b1 ||
            bus.pix_addr !== '0 || bus.pix_iter !== '0) begin
            fails++;
            $display("FAIL midreset_state got b=%b v=%b er=%b a=%0d it=%0d want 0 0 1 0 0",
                     busy, bus.pix_valid, bus.eng_reset, bus.pix_addr, bus.pix_iter);
        end
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.pix_valid || busy) seen = 1'b1;
        end
        tests++; if (seen || done_cnt != d0) begin
            fails++; $display("FAIL midreset_quiet got activity=%b dones=%0d want 0 0", seen, done_cnt - d0);
        end
        launch(32'hFE000000, 32'h01000000, 32'h00800000, 32'd16);
        collect(300);
        tests++;
        if (cap_n != 8 || !cap_done || cap_addr[0] !== 3'd0 ||
            cap_iter[0] !== 8'd1 || cap_x[0] !== 32'hFE000000) begin
            fails++;
            $display("FAIL restart got n=%0d a0=%0d it0=%0d x0=%h want 8 0 1 fe000000",
                     cap_n, cap_addr[0], cap_iter[0], cap_x[0]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want $finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_frame();
        test_limits();
        test_stall();
        test_saturate();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
